// File: rtl/mont_enc.sv
// Streaming normal-to-Montgomery converter for Kyber coefficients: out = a * 2^16 mod q.
// Four-stage stall-all pipeline: multiply by R^2 mod q, then Montgomery reduce, then canonicalise.
`timescale 1ns/1ps
module mont_enc #(
  parameter int Q      = 3329,
  parameter int QINV   = 62209,
  parameter int R2MODQ = 1353,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int PW = 2 * DW;
  localparam logic signed [PW-1:0] R2_W   = PW'(R2MODQ);
  localparam logic signed [PW-1:0] Q_W    = PW'(Q);
  localparam logic signed [DW-1:0] Q_N    = DW'(Q);
  localparam logic        [DW-1:0] QINV_U = DW'(QINV);

  logic                 adv;
  logic [3:0]           vld_q, vld_d;
  logic [3:0]           lst_q, lst_d;
  logic signed [PW-1:0] p1_q, p1_d;
  logic signed [PW-1:0] p2_q, p2_d;
  logic [DW-1:0]        t2_q, t2_d;
  logic signed [PW-1:0] d3_q, d3_d;
  logic [DW-1:0]        o4_q, o4_d;
  logic signed [PW-1:0] t2_ext;
  logic signed [DW-1:0] r4;
  logic                 unused_lo;

  always_comb begin
    adv    = !vld_q[3] || out_ready;
    vld_d  = {vld_q[2:0], in_valid};
    lst_d  = {lst_q[2:0], in_last};
    p1_d   = $signed({{DW{in_data[DW-1]}}, in_data}) * R2_W;
    // Only the low half of p matters for the quotient estimate t.
    t2_d   = p1_q[DW-1:0] * QINV_U;
    p2_d   = p1_q;
    t2_ext = $signed({{DW{t2_q[DW-1]}}, t2_q});
    d3_d   = p2_q - t2_ext * Q_W;
    // Low half of d is zero by construction; r lies in (-q, q).
    r4     = d3_q[PW-1:DW];
    if (r4[DW-1]) o4_d = r4 + Q_N;
    else          o4_d = r4;
  end

  assign unused_lo = ^d3_q[DW-1:0];

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_q <= '0;
      lst_q <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      t2_q  <= '0;
      d3_q  <= '0;
      o4_q  <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      lst_q <= lst_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      t2_q  <= t2_d;
      d3_q  <= d3_d;
      o4_q  <= o4_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[3];
  assign out_last  = lst_q[3];
  assign out_data  = o4_q;

endmodule

// File: tb/tb_mont_enc.sv
// Randomised bench for mont_enc: a scoreboard of a*2^16 mod 3329 values checked at the output,
// plus latency, reset, stall-hold and in_ready checks.
`timescale 1ns/1ps
module tb_mont_enc;

  logic        clk = 1'b0;
  logic        srst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int data;
    bit last;
  } exp_t;
  exp_t sb[$];

  bit       stall_prev = 1'b0;
  int       held_data  = 0;
  bit       held_last  = 1'b0;

  mont_enc dut (
    .clk      (clk),
    .srst     (srst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  function automatic int ref_model(input int a);
    longint v;
    v = longint'(a) * 65536;
    v = v % 3329;
    if (v < 0) v = v + 3329;
    return int'(v);
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present one cycle of inputs; they are held through the next rising edge.
  task automatic step(input bit v, input int a, input bit l, input bit r);
    in_valid  = v;
    in_data   = a[15:0];
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic latency_one(input int a, input int exp);
    int lat;
    step(1'b1, a, 1'b1, 1'b1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      step(1'b0, 0, 1'b0, 1'b1);
      lat++;
    end
    check_eq("latency", lat, 4);
    check_eq("lat_data", int'(out_data), exp);
    check_eq("lat_last", int'(out_last), 1);
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 0, 1'b0, 1'b1);
    check_eq("drain_empty", sb.size(), 0);
  endtask

  // Handshakes are evaluated mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (srst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      check_eq("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        check_eq("hold_valid", int'(out_valid), 1);
        check_eq("hold_data", int'(out_data), held_data);
        check_eq("hold_last", int'(out_last), int'(held_last));
      end
      if (sb.size() == 0) begin
        check_eq("spurious_valid", int'(out_valid), 0);
      end else if (out_valid && out_ready) begin
        e = sb.pop_front();
        check_eq("data", int'(out_data), e.data);
        check_eq("last", int'(out_last), int'(e.last));
      end
      if (in_valid && in_ready) begin
        e.data = ref_model(int'($signed(in_data)));
        e.last = in_last;
        sb.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      held_data  = int'(out_data);
      held_last  = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int extremes[10] = '{0, 1, -1, 3328, -32768, 32767, 3329, -3329, 6658, -2};

  initial begin
    srst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    srst = 1'b0;
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_data", int'(out_data), 0);
    check_eq("rst_last", int'(out_last), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);

    latency_one(1, 2285);
    drain();
    latency_one(0, 0);
    drain();

    foreach (extremes[i]) step(1'b1, extremes[i], i == 9, 1'b1);
    drain();

    for (int i = 0; i < 1000; i++) step(1'b1, int'($urandom), (i % 37) == 36, 1'b1);
    drain();

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 1) == 1, int'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    drain();

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0);
    drain();

    // Reset with elements in flight: none of them may emerge.
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b1, 6, 1'b0, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1);
    srst = 1'b1;
    step(1'b0, 0, 1'b0, 1'b1);
    srst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("post_rst_valid", int'(out_valid), 0);
      step(1'b0, 0, 1'b0, 1'b1);
    end
    latency_one(1, 2285);
    drain();

    for (int a = -32768; a <= 32767; a += 13) step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, 32767, 1'b1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
